// File: rtl/spi_slave_rx.sv
// spi_slave_rx: receive-only SPI slave (sample on sclk rise, MSB first) with a valid/ready byte output.
// Define SPI_RX_SYNC_EN for two-flop input synchronizers; the default build uses a single flop per input.
module spi_slave_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);
    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

    logic sclk_s, mosi_s, cs_s;

`ifdef SPI_RX_SYNC_EN
    logic [1:0] sclk_sync_q, sclk_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;
    logic [1:0] cs_sync_q, cs_sync_d;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[0], sclk};
        mosi_sync_d = {mosi_sync_q[0], mosi};
        cs_sync_d   = {cs_sync_q[0], cs};
    end

    // Reset values describe an idle bus so no edge or frame is seen at release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_q <= 2'b00;
            mosi_sync_q <= 2'b00;
            cs_sync_q   <= 2'b11;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
        end
    end

    assign sclk_s = sclk_sync_q[1];
    assign mosi_s = mosi_sync_q[1];
    assign cs_s   = cs_sync_q[1];
`else
    logic sclk_sync_q, sclk_sync_d;
    logic mosi_sync_q, mosi_sync_d;
    logic cs_sync_q, cs_sync_d;

    always_comb begin
        sclk_sync_d = sclk;
        mosi_sync_d = mosi;
        cs_sync_d   = cs;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            cs_sync_q   <= 1'b1;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
        end
    end

    assign sclk_s = sclk_sync_q;
    assign mosi_s = mosi_sync_q;
    assign cs_s   = cs_sync_q;
`endif

    state_t     state_q, state_d;
    logic       sclk_prev_q, sclk_prev_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] dout_q, dout_d;
    logic       dout_valid_q, dout_valid_d;
    logic       overrun_q, overrun_d;
    logic       frame_err_q, frame_err_d;
    logic       sclk_rise, byte_done, xfer;

    // Handshake: a byte moves on a clk edge where dout_valid and dout_ready are both high;
    // dout_valid never drops without a transfer and dout is stable while it waits.
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign xfer      = dout_valid_q & dout_ready;
    assign byte_done = (state_q == RECV) & ~cs_s & sclk_rise & (bit_cnt_q == 3'd7);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!cs_s) state_d = RECV;
            RECV: if (cs_s)  state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RECV);
    end

    always_comb begin
        sclk_prev_d  = sclk_s;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = 1'b0;
        frame_err_d  = 1'b0;
        if (state_q == IDLE) begin
            if (!cs_s) begin
                bit_cnt_d = 3'd0;
                shift_d   = 8'd0;
            end
        end else if (cs_s) begin
            frame_err_d = (bit_cnt_q != 3'd0);
        end else if (sclk_rise) begin
            shift_d   = {shift_q[6:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (xfer) dout_valid_d = 1'b0;
        // A completing byte may reuse the slot being emptied in the same cycle.
        if (byte_done) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = {shift_q[6:0], mosi_s};
                dout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_prev_q  <= 1'b0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            dout_q       <= 8'd0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sclk_prev_q  <= sclk_prev_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed and randomized SPI frames against a byte-level expectation queue.
// Honours SPI_RX_SYNC_EN the same way as the design for the latency expectation.
module tb_spi_slave_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       cs = 1'b1;
    logic       dout_ready = 1'b0;
    logic [7:0] dout;
    logic       dout_valid, overrun, frame_err, busy;

`ifdef SPI_RX_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int ov_seen = 0;
    int fe_seen = 0;
    int exp_ov = 0;
    int exp_fe = 0;
    int ready_mode = 0;
    int low_streak = 0;
    logic [7:0] exp_q[$];

    spi_slave_rx dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs(cs),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .overrun(overrun), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Ready driver: fixed low, fixed high, or random with low streaks capped at 3 cycles.
    initial forever begin
        @(posedge clk);
        #2;
        case (ready_mode)
            0: dout_ready = 1'b0;
            1: dout_ready = 1'b1;
            default: begin
                if (low_streak >= 3) dout_ready = 1'b1;
                else dout_ready = 1'($urandom_range(0, 1));
                low_streak = dout_ready ? 0 : low_streak + 1;
            end
        endcase
    end

    // Scoreboard: every transfer must deliver the oldest expected byte.
    always @(negedge clk) begin
        if (rst) begin
            if (overrun) ov_seen++;
            if (frame_err) fe_seen++;
            if (dout_valid && dout_ready) begin
                check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("byte_data", {24'd0, dout}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic send_bits(input logic [7:0] b, input int nbits, input bit push, input bit measure);
        int n;
        for (int i = 0; i < nbits; i++) begin
            mosi = b[3'(7 - i)];
            sclk = 1'b0;
            tick(4);
            sclk = 1'b1;
            if (i == 7 && push) exp_q.push_back(b);
            if (i == 7 && measure) begin
                n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!dout_valid && n < 8);
                check("latency", n, LAT);
                #1;
                tick(3);
            end else begin
                tick(4);
            end
        end
        sclk = 1'b0;
    endtask

    task automatic cs_low();
        cs = 1'b0;
        tick(4);
    endtask

    task automatic cs_high(input bit partial);
        sclk = 1'b0;
        tick(4);
        cs = 1'b1;
        if (partial) exp_fe++;
        tick(8);
    endtask

    initial begin
        logic [7:0] b;
        int nb, part;

        tick(3);
        check("rst_dout", {24'd0, dout}, 32'h0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        tick(2);

        // Single byte held with no consumer; also measures completion latency.
        ready_mode = 0;
        tick(2);
        cs_low();
        send_bits(8'hAE, 8, 1'b1, 1'b1);
        cs_high(1'b0);
        check("hold_dout", {24'd0, dout}, 32'hAE);
        check("hold_valid", 32'(dout_valid), 32'd1);
        tick(20);
        check("hold_valid_late", 32'(dout_valid), 32'd1);
        check("hold_dout_late", {24'd0, dout}, 32'hAE);
        check("hold_no_overrun", ov_seen, exp_ov);
        ready_mode = 1;
        tick(4);
        check("drain_valid", 32'(dout_valid), 32'd0);
        check("drain_queue", exp_q.size(), 0);

        // Two bytes in one frame, consumer always ready.
        cs_low();
        send_bits(8'hAE, 8, 1'b1, 1'b0);
        check("busy_byte1", 32'(busy), 32'd1);
        send_bits(8'h55, 8, 1'b1, 1'b0);
        check("busy_byte2", 32'(busy), 32'd1);
        cs_high(1'b0);
        check("busy_idle", 32'(busy), 32'd0);
        check("two_byte_queue", exp_q.size(), 0);

        // Second byte arrives while the first is still unconsumed.
        ready_mode = 0;
        tick(2);
        cs_low();
        send_bits(8'h12, 8, 1'b1, 1'b0);
        send_bits(8'h34, 8, 1'b0, 1'b0);
        exp_ov++;
        cs_high(1'b0);
        check("ovr_dout", {24'd0, dout}, 32'h12);
        check("ovr_valid", 32'(dout_valid), 32'd1);
        check("ovr_count", ov_seen, exp_ov);
        ready_mode = 1;
        tick(4);
        check("ovr_queue", exp_q.size(), 0);

        // Aborted frame, then a clean one.
        cs_low();
        send_bits(8'($urandom), 3, 1'b0, 1'b0);
        cs_high(1'b1);
        check("ferr_count", fe_seen, exp_fe);
        check("ferr_valid", 32'(dout_valid), 32'd0);
        cs_low();
        send_bits(8'hC3, 8, 1'b1, 1'b0);
        cs_high(1'b0);
        check("after_ferr_queue", exp_q.size(), 0);
        check("after_ferr_count", fe_seen, exp_fe);

        // Reset with a held byte and a partial byte in flight.
        ready_mode = 0;
        tick(2);
        cs_low();
        send_bits(8'hA5, 8, 1'b1, 1'b0);
        cs_high(1'b0);
        check("pre_rst_dout", {24'd0, dout}, 32'hA5);
        cs_low();
        send_bits(8'($urandom), 5, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("mid_rst_dout", {24'd0, dout}, 32'h0);
        check("mid_rst_valid", 32'(dout_valid), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        check("mid_rst_frame_err", 32'(frame_err), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        cs = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(4);
        check("post_rst_busy", 32'(busy), 32'd0);
        cs_low();
        send_bits(8'hFF, 8, 1'b1, 1'b0);
        cs_high(1'b0);
        check("post_rst_dout", {24'd0, dout}, 32'hFF);
        check("post_rst_valid", 32'(dout_valid), 32'd1);
        check("post_rst_overrun", ov_seen, exp_ov);
        check("post_rst_frame_err", fe_seen, exp_fe);
        ready_mode = 1;
        tick(4);
        check("post_rst_queue", exp_q.size(), 0);

        // Random frames: 0-3 whole bytes, optionally a trailing partial byte, random consumer.
        ready_mode = 2;
        for (int f = 0; f < 20; f++) begin
            nb = int'($urandom_range(0, 3));
            part = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 7)) : 0;
            cs_low();
            for (int k = 0; k < nb; k++) begin
                b = 8'($urandom);
                send_bits(b, 8, 1'b1, 1'b0);
            end
            if (part != 0) send_bits(8'($urandom), part, 1'b0, 1'b0);
            cs_high(part != 0);
        end
        ready_mode = 1;
        tick(8);
        check("rand_queue", exp_q.size(), 0);
        check("rand_overrun", ov_seen, exp_ov);
        check("rand_frame_err", fe_seen, exp_fe);
        check("rand_valid", 32'(dout_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
